// File: rtl/toggle_mon_pkg.sv
// Shared types and reset constants for the toggle activity monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t    - 2-bit FSM encoding (IDLE, PRIME, COUNT, DONE)
//   RST_*      - values every register returns to on rst
package toggle_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam state_t RST_STATE = ST_IDLE;
  localparam logic   RST_VALID = 1'b0;
  localparam logic   RST_OVF   = 1'b0;

endpackage

// File: rtl/popcount_xor.sv
// Counts how many bits differ between the current and previous sample.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   cur   in  WIDTH  current sample of the observed bundle
//   prev  in  WIDTH  sample from the previous counted cycle
//   cnt   out PC_W   number of bits that toggled (0..WIDTH)
module popcount_xor #(
  parameter  int WIDTH = 8,
  localparam int PC_W  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] prev,
  output logic [PC_W-1:0]  cnt
);

  logic [WIDTH-1:0] diff;

  always_comb begin
    diff = cur ^ prev;
    cnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + PC_W'(diff[i]);
    end
  end

endmodule

// File: rtl/toggle_activity_counter.sv
// Counts bit transitions of sig_in over a window of win_len cycles.
// Latency: result valid 1 cycle after the last counted cycle (win_len + 2 cycles from start).
// Backpressure: result held stable in DONE until res_valid & res_ready; no sampling meanwhile.
//
// Build option: define TOGGLE_SAT_EN to make the accumulator saturate at
// 2^CNT_W-1 instead of wrapping. res_ovf flags overflow in both builds.
//
// Ports:
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      synchronous active-high reset
//   sig_in     in   WIDTH  observed signal bundle
//   en         in   1      start/keep measuring; low aborts a window in progress
//   win_len    in   WIN_W  counted cycles per window, latched at window start
//   res_valid  out  1      result available
//   res_ready  in   1      consumer accepts result
//   res_count  out  CNT_W  toggles counted in the completed window
//   res_ovf    out  1      accumulator overflowed during the window
module toggle_activity_counter
  import toggle_mon_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_in,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf
);

  localparam int PC_W = $clog2(WIDTH + 1);

  state_t state, state_nxt;

  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] cyc_q;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] acc_q;
  logic             ovf_q;

  logic [PC_W-1:0]  inc;
  logic [CNT_W:0]   sum;
  logic             carry;
  logic [CNT_W-1:0] acc_nxt;
  logic             ovf_nxt;

  logic start_ok;
  logic last_cyc;

  // FSM control strobes
  logic load_win;
  logic do_prime;
  logic do_count;
  logic do_finish;
  logic do_accept;

  popcount_xor #(.WIDTH(WIDTH)) u_popcount (
    .cur  (sig_in),
    .prev (prev_q),
    .cnt  (inc)
  );

  // A zero-length window is meaningless, so it never starts one.
  assign start_ok = en && (win_len != '0);
  // cyc_q counts completed counted cycles; this is the final one.
  assign last_cyc = (cyc_q == (win_q - WIN_W'(1)));

  // ---------------------------------------------------------------------------
  // Accumulator datapath: one extra bit catches the carry-out for overflow.
  // ---------------------------------------------------------------------------
  always_comb begin
    sum   = {1'b0, acc_q} + (CNT_W + 1)'(inc);
    carry = sum[CNT_W];
`ifdef TOGGLE_SAT_EN
    acc_nxt = carry ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
`else
    acc_nxt = sum[CNT_W-1:0];
`endif
    ovf_nxt = ovf_q | carry;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        state_nxt = en ? ST_COUNT : ST_IDLE;
      end
      ST_COUNT: begin
        if (!en)          state_nxt = ST_IDLE;
        else if (last_cyc) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // en is deliberately ignored until the result has been taken.
        if (res_ready) state_nxt = start_ok ? ST_PRIME : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    load_win  = 1'b0;
    do_prime  = 1'b0;
    do_count  = 1'b0;
    do_finish = 1'b0;
    do_accept = 1'b0;
    case (state)
      ST_IDLE:  load_win = start_ok;
      ST_PRIME: do_prime = en;
      ST_COUNT: begin
        do_count  = en;
        do_finish = en && last_cyc;
      end
      ST_DONE: begin
        do_accept = res_ready;
        load_win  = res_ready && start_ok;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Window counter, accumulator and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q     <= '0;
      cyc_q     <= '0;
      prev_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= RST_OVF;
      res_valid <= RST_VALID;
      res_count <= '0;
      res_ovf   <= RST_OVF;
    end else begin
      if (load_win) begin
        win_q <= win_len;
      end

      if (do_prime) begin
        // Establish the reference sample; nothing is counted this cycle.
        prev_q <= sig_in;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
        cyc_q  <= '0;
      end

      if (do_count) begin
        prev_q <= sig_in;
        acc_q  <= acc_nxt;
        ovf_q  <= ovf_nxt;
        cyc_q  <= cyc_q + WIN_W'(1);
      end

      // Capture includes the final cycle's increment, so the result is
      // ready exactly one cycle after the last counted cycle.
      if (do_finish) begin
        res_count <= acc_nxt;
        res_ovf   <= ovf_nxt;
        res_valid <= 1'b1;
      end else if (do_accept) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_activity_counter.sv
module tb_toggle_activity_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: WIDTH=8, CNT_W=16
  logic        rst;
  logic [7:0]  sig_in;
  logic        en;
  logic [7:0]  win_len;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_count;
  logic        res_ovf;

  // Narrow instance for overflow: CNT_W=4
  logic [7:0]  sig2;
  logic        en2;
  logic [7:0]  win2;
  logic        valid2;
  logic        ready2;
  logic [3:0]  count2;
  logic        ovf2;

  toggle_activity_counter #(.WIDTH(8), .CNT_W(16), .WIN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .en        (en),
    .win_len   (win_len),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_ovf   (res_ovf)
  );

  toggle_activity_counter #(.WIDTH(8), .CNT_W(4), .WIN_W(8)) dut_narrow (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig2),
    .en        (en2),
    .win_len   (win2),
    .res_valid (valid2),
    .res_ready (ready2),
    .res_count (count2),
    .res_ovf   (ovf2)
  );

  typedef struct packed {
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Toggles sig_in by mask after every edge until res_valid is seen.
  task automatic drive_until_valid(input logic [7:0] mask, input int limit,
                                   output int lat, output bit timed_out);
    lat       = 0;
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      tick();
      lat++;
      if (res_valid === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      sig_in = sig_in ^ mask;
    end
  endtask

  task automatic pop_and_check(input string name);
    exp_t e;
    e = sb.pop_front();
    n_tests++;
    if (res_count !== e.cnt) begin
      n_fail++;
      $display("FAIL %s count: got %0d expected %0d", name, res_count, e.cnt);
    end
    n_tests++;
    if (res_ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL %s ovf: got %0b expected %0b", name, res_ovf, e.ovf);
    end
  endtask

  task automatic test_reset();
    int lat; bit to;
    rst = 1'b1; en = 1'b1; win_len = 8'd5; res_ready = 1'b1; sig_in = 8'h00;
    repeat (2) tick();
    n_tests++;
    if (res_valid !== 1'b0 || res_count !== 16'd0 || res_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b c=%0d o=%0b expected 0/0/0", res_valid, res_count, res_ovf);
    end
    rst = 1'b0;
    sb.push_back('{cnt: 16'd5, ovf: 1'b0});
    drive_until_valid(8'h01, 50, lat, to);
    n_tests++;
    if (to || lat != 7) begin
      n_fail++;
      $display("FAIL reset_first_window_latency: got %0d (timeout=%0b) expected 7", lat, to);
    end
    if (!to) pop_and_check("reset_first_window");
    else void'(sb.pop_front());
    en = 1'b0;
    tick();
  endtask

  task automatic test_tff();
    int lat; bit to;
    en = 1'b1; win_len = 8'd10; res_ready = 1'b1; sig_in = 8'h00;
    sb.push_back('{cnt: 16'd10, ovf: 1'b0});
    drive_until_valid(8'h01, 100, lat, to);
    n_tests++;
    if (to || lat != 12) begin
      n_fail++;
      $display("FAIL tff_latency: got %0d (timeout=%0b) expected 12", lat, to);
    end
    if (!to) pop_and_check("tff");
    else void'(sb.pop_front());
    en = 1'b0;
    tick();
    n_tests++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL tff_valid_pulse: got %0b expected 0", res_valid);
    end
  endtask

  task automatic test_alternating();
    int lat; bit to;
    en = 1'b1; win_len = 8'd4; res_ready = 1'b1; sig_in = 8'h00;
    sb.push_back('{cnt: 16'd32, ovf: 1'b0});
    drive_until_valid(8'hFF, 100, lat, to);
    n_tests++;
    if (to || lat != 6) begin
      n_fail++;
      $display("FAIL alt_latency: got %0d (timeout=%0b) expected 6", lat, to);
    end
    if (!to) pop_and_check("alternating");
    else void'(sb.pop_front());
    en = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    en = 1'b1; win_len = 8'd4; res_ready = 1'b0; sig_in = 8'h00;
    sb.push_back('{cnt: 16'd32, ovf: 1'b0});
    drive_until_valid(8'hFF, 100, lat, to);
    if (!to) pop_and_check("bp_first");
    else void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      sig_in = sig_in ^ 8'h5A;
      en     = (i == 4);    // en low while stalled must not drop the result
      tick();
      n_tests++;
      if (res_valid !== 1'b1 || res_count !== 16'd32) begin
        n_fail++;
        $display("FAIL bp_stable[%0d]: got v=%0b c=%0d expected v=1 c=32", i, res_valid, res_count);
      end
    end
    // Accept with en high: next window goes straight to PRIME.
    res_ready = 1'b1; en = 1'b1; win_len = 8'd3;
    sb.push_back('{cnt: 16'd3, ovf: 1'b0});
    drive_until_valid(8'h01, 100, lat, to);
    n_tests++;
    if (to || lat != 5) begin
      n_fail++;
      $display("FAIL bp_restart_latency: got %0d (timeout=%0b) expected 5", lat, to);
    end
    if (!to) pop_and_check("bp_second");
    else void'(sb.pop_front());
    en = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit seen;
    en = 1'b1; win_len = 8'd10; res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      sig_in = sig_in ^ 8'h01;
    end
    en   = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sig_in = sig_in ^ 8'h01;
      if (res_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_valid: got valid=1 expected 0");
    end
    n_tests++;
    if (res_count !== 16'd3) begin
      n_fail++;
      $display("FAIL abort_count_kept: got %0d expected 3", res_count);
    end
  endtask

  task automatic test_win_zero();
    bit seen; int lat; bit to;
    en = 1'b1; win_len = 8'd0; res_ready = 1'b1; seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      sig_in = sig_in ^ 8'h0F;
      if (res_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL win_zero_ignored: got valid=1 expected 0");
    end
    win_len = 8'd2;
    sb.push_back('{cnt: 16'd8, ovf: 1'b0});
    drive_until_valid(8'h0F, 50, lat, to);
    n_tests++;
    if (to || lat != 4) begin
      n_fail++;
      $display("FAIL win_zero_then_two_latency: got %0d (timeout=%0b) expected 4", lat, to);
    end
    if (!to) pop_and_check("win_two");
    else void'(sb.pop_front());
    en = 1'b0;
    tick();
  endtask

  task automatic test_rst_in_done();
    int lat; bit to;
    en = 1'b1; win_len = 8'd3; res_ready = 1'b0;
    drive_until_valid(8'hFF, 50, lat, to);
    n_tests++;
    if (to || res_count !== 16'd24) begin
      n_fail++;
      $display("FAIL rst_done_setup: got c=%0d (timeout=%0b) expected 24", res_count, to);
    end
    en  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (res_valid !== 1'b0 || res_count !== 16'd0 || res_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_done: got v=%0b c=%0d o=%0b expected 0/0/0", res_valid, res_count, res_ovf);
    end
    res_ready = 1'b1;
  endtask

  task automatic run_narrow(input logic [7:0] wl, input string name);
    exp_t e;
    bit   got;
    en2 = 1'b1; win2 = wl; ready2 = 1'b1; sig2 = 8'h00; got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (valid2 === 1'b1) begin
        got = 1'b1;
        break;
      end
      sig2 = sig2 ^ 8'hFF;
    end
    e = sb2.pop_front();
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s timeout: no res_valid within 50 cycles", name);
    end else begin
      if (count2 !== e.cnt[3:0]) begin
        n_fail++;
        $display("FAIL %s count: got %0d expected %0d", name, count2, e.cnt[3:0]);
      end
      n_tests++;
      if (ovf2 !== e.ovf) begin
        n_fail++;
        $display("FAIL %s ovf: got %0b expected %0b", name, ovf2, e.ovf);
      end
    end
    en2 = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
`ifdef TOGGLE_SAT_EN
    sb2.push_back('{cnt: 16'd15, ovf: 1'b1});
`else
    sb2.push_back('{cnt: 16'd0, ovf: 1'b1});
`endif
    run_narrow(8'd2, "overflow_16");
    // Sticky flag must clear for the next window.
    sb2.push_back('{cnt: 16'd8, ovf: 1'b0});
    run_narrow(8'd1, "narrow_no_ovf");
  endtask

  initial begin
    en2 = 1'b0; win2 = 8'd0; ready2 = 1'b1; sig2 = 8'h00;
    test_reset();
    test_tff();
    test_alternating();
    test_backpressure();
    test_abort();
    test_win_zero();
    test_rst_in_done();
    test_overflow();
    n_tests++;
    if (sb.size() != 0 || sb2.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries expected 0/0", sb.size(), sb2.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
